// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a synchronous FIFO whose read data appears one cycle after the read
// strobe and presents the words on a ready/valid stream. A 2-entry buffer
// (head/tail) absorbs the read latency so that a consumer holding ready high
// receives one word per cycle. Reads are only issued when the word they return
// is guaranteed a free buffer slot, so the buffer can never overflow.

module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 fifo_empty,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic [CNT_WIDTH-1:0] words_sent,
    output logic                 idle
);

    // Buffer occupancy, encoded so the state value equals the word count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t             occ;
    occ_t             occ_next;
    logic             pending;
    logic             pop;
    logic [2:0]       fill;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;

    // Occupancy register plus the read-in-flight flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ     <= OCC_EMPTY;
            pending <= 1'b0;
        end else begin
            occ     <= occ_next;
            pending <= fifo_rd_en;
        end
    end

    // Handshake detection, read issue and next occupancy; fill counts words held
    // after this edge including the one already in flight.
    always_comb begin
        pop        = data_out_valid & data_out_ready;
        fill       = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
        fifo_rd_en = rst & ~fifo_empty & (fill < 3'd2);
        occ_next   = occ_t'(fill[1:0]);
    end

    // Buffer data movement: arriving words go to the first free slot after any
    // pop, and a pop from a full buffer shifts the tail forward into the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else if (pending) begin
            if ((occ == OCC_EMPTY) || ((occ == OCC_ONE) && pop)) begin
                head <= fifo_dout;
            end else if (occ == OCC_ONE) begin
                tail <= fifo_dout;
            end else begin
                head <= tail;
                tail <= fifo_dout;
            end
        end else if (pop && (occ == OCC_FULL)) begin
            head <= tail;
        end
    end

    // Completed-handshake counter, wrapping silently at its width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words_sent <= '0;
        end else if (pop) begin
            words_sent <= words_sent + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign data_out       = head;
    assign data_out_valid = (occ != OCC_EMPTY);
    assign idle           = (occ == OCC_EMPTY) & ~pending & fifo_empty;

endmodule
